// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor slice:
// 2-bit counter type, counter constants, saturating ops, in-flight entry.
package bp_pkg;

   typedef logic [1:0] ctr_t;

   localparam ctr_t SNT = 2'd0;
   localparam ctr_t WNT = 2'd1;
   localparam ctr_t WT  = 2'd2;
   localparam ctr_t ST  = 2'd3;

   // In-flight entries carry a fixed-width index field; tables
   // narrower than this use the low bits and zero-fill the rest.
   localparam int W_IDX_MAX = 16;

   typedef struct packed {
      logic [W_IDX_MAX-1:0] idx;
      logic                 pred;
   } inflight_t;

   function automatic ctr_t sat_inc(input ctr_t c);
      return (c == ST) ? ST : ctr_t'(c + 2'd1);
   endfunction

   function automatic ctr_t sat_dec(input ctr_t c);
      return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
   endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-flight prediction FIFO: DEPTH entries, push/pop, full/empty flags.
// Ports: clk, rst (async high), push, pop, din, dout (head), full, empty.
module bp_inflight_fifo
   import bp_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  logic      pop,
   input  inflight_t din,
   output inflight_t dout,
   output logic      full,
   output logic      empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   inflight_t       mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;

   // Caller qualifies push/pop; push while full is legal only with pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/gshare_pht.sv
// Gshare pattern history table: idx = pc[W_PHT+1:2] ^ gbhr, 2-bit counters,
// registered prediction, in-flight index queue for resolve-time update.
// Ports: clk, rst, EN, predict, pc, gbhr, resolve, br_taken ->
//        pred_valid, pred_taken, pred_ctr, mispredict, q_full, q_empty.
// Option: PHT_BYPASS_EN forwards a same-cycle update to the prediction.
module gshare_pht
   import bp_pkg::*;
#(
   parameter int         W_PHT    = 4,
   parameter int         W_PC     = 32,
   parameter int         DEPTH    = 4,
   parameter logic [1:0] INIT_CTR = 2'b01
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             EN,
   input  logic             predict,
   input  logic [W_PC-1:0]  pc,
   input  logic [W_PHT-1:0] gbhr,
   input  logic             resolve,
   input  logic             br_taken,
   output logic             pred_valid,
   output logic             pred_taken,
   output logic [1:0]       pred_ctr,
   output logic             mispredict,
   output logic             q_full,
   output logic             q_empty
);

   localparam int N = 2 ** W_PHT;

   ctr_t             ctr [N];
   logic [W_PHT-1:0] idx;
   logic [W_PHT-1:0] head_idx;
   inflight_t        head;
   inflight_t        push_ent;
   logic             res_acc;
   logic             pred_acc;
   ctr_t             upd_val;
   ctr_t             rd_val;
   logic             unused;

   assign idx      = pc[W_PHT+1:2] ^ gbhr;
   assign head_idx = head.idx[W_PHT-1:0];

   assign res_acc  = EN && resolve && !q_empty;
   // A full queue still accepts a predict when a pop frees a slot.
   assign pred_acc = EN && predict && (!q_full || res_acc);

   assign upd_val = br_taken ? sat_inc(ctr[head_idx])
                             : sat_dec(ctr[head_idx]);

`ifdef PHT_BYPASS_EN
   assign rd_val = (res_acc && head_idx == idx) ? upd_val : ctr[idx];
`else
   assign rd_val = ctr[idx];
`endif

   always_comb begin
      push_ent      = '0;
      push_ent.idx  = W_IDX_MAX'(idx);
      push_ent.pred = rd_val[1];
   end

   bp_inflight_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (pred_acc),
      .pop   (res_acc),
      .din   (push_ent),
      .dout  (head),
      .full  (q_full),
      .empty (q_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) ctr[i] <= INIT_CTR;
         pred_valid <= 1'b0;
         pred_taken <= 1'b0;
         pred_ctr   <= 2'b00;
         mispredict <= 1'b0;
      end else begin
         pred_valid <= pred_acc;
         mispredict <= res_acc && (head.pred != br_taken);
         if (pred_acc) begin
            pred_ctr   <= rd_val;
            pred_taken <= rd_val[1];
         end
         if (res_acc) ctr[head_idx] <= upd_val;
      end
   end

   assign unused = ^{pc, head.idx};

endmodule

// File: tb/tb_gshare_pht.sv
// Directed bench for gshare_pht with a queue/array reference model.
// Inputs change just after negedge; outputs compared every negedge.
module tb_gshare_pht;

   localparam int DEPTH = 4;
`ifdef PHT_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        EN = 1'b1;
   logic        predict = 1'b0;
   logic [31:0] pc = '0;
   logic [3:0]  gbhr = '0;
   logic        resolve = 1'b0;
   logic        br_taken = 1'b0;
   logic        pred_valid, pred_taken, mispredict, q_full, q_empty;
   logic [1:0]  pred_ctr;

   gshare_pht #(
      .W_PHT(4), .W_PC(32), .DEPTH(DEPTH), .INIT_CTR(2'b01)
   ) dut (
      .clk(clk), .rst(rst), .EN(EN), .predict(predict), .pc(pc),
      .gbhr(gbhr), .resolve(resolve), .br_taken(br_taken),
      .pred_valid(pred_valid), .pred_taken(pred_taken),
      .pred_ctr(pred_ctr), .mispredict(mispredict),
      .q_full(q_full), .q_empty(q_empty)
   );

   always #5 clk = ~clk;

   typedef struct { int idx; bit pred; } ent_t;
   ent_t q[$];
   int   m_ctr [16];
   bit   exp_pv, exp_tk, exp_mis, exp_full, exp_empty;
   int   exp_ctr;
   bit   chk_on = 1'b0;
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      for (int i = 0; i < 16; i++) m_ctr[i] = 1;
      exp_pv = 0; exp_tk = 0; exp_ctr = 0; exp_mis = 0;
      exp_full = 0; exp_empty = 1;
   endtask

   // Reference behaviour evaluated at a rising edge from current inputs.
   task automatic model_edge();
      int i, rv, nv;
      bit rok, pok;
      ent_t h;
      exp_pv = 0;
      exp_mis = 0;
      if (EN) begin
         rok = resolve && q.size() > 0;
         pok = predict && (q.size() < DEPTH || rok);
         i = int'((pc >> 2) & 32'hF) ^ int'(gbhr);
         rv = m_ctr[i];
         if (rok) begin
            h = q.pop_front();
            if (br_taken) nv = (m_ctr[h.idx] == 3) ? 3 : m_ctr[h.idx] + 1;
            else          nv = (m_ctr[h.idx] == 0) ? 0 : m_ctr[h.idx] - 1;
            if (BYP && h.idx == i) rv = nv;
            m_ctr[h.idx] = nv;
            exp_mis = (h.pred != br_taken);
         end
         if (pok) begin
            exp_pv = 1;
            exp_ctr = rv;
            exp_tk = (rv >= 2);
            q.push_back('{i, rv >= 2});
         end
      end
      exp_full = (q.size() == DEPTH);
      exp_empty = (q.size() == 0);
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("pred_valid", int'(pred_valid), int'(exp_pv));
         chk("pred_ctr", int'(pred_ctr), exp_ctr);
         chk("pred_taken", int'(pred_taken), int'(exp_tk));
         chk("mispredict", int'(mispredict), int'(exp_mis));
         chk("q_full", int'(q_full), int'(exp_full));
         chk("q_empty", int'(q_empty), int'(exp_empty));
      end
   end

   task automatic step(input bit e, input bit p, input logic [31:0] a,
                       input logic [3:0] g, input bit r, input bit bt);
      EN = e; predict = p; pc = a; gbhr = g; resolve = r; br_taken = bt;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      #1;
      EN = 1; predict = 0; resolve = 0; br_taken = 0;
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_q_empty", int'(q_empty), 1);
      chk("rst_q_full", int'(q_full), 0);
      chk("rst_pred_valid", int'(pred_valid), 0);
      rst = 0;
      chk_on = 1;

      // 1: first prediction at idx 4
      step(1, 1, 32'h10, 4'h0, 0, 0);
      chk("t1_pred_valid", int'(pred_valid), 1);
      chk("t1_pred_ctr", int'(pred_ctr), 1);
      chk("t1_q_empty", int'(q_empty), 0);

      // 2: train idx 4 to strongly taken
      step(1, 1, 32'h10, 4'h0, 0, 0);
      step(1, 0, 32'h0, 4'h0, 1, 1);
      chk("t2_mis_a", int'(mispredict), 1);
      step(1, 0, 32'h0, 4'h0, 1, 1);
      chk("t2_mis_b", int'(mispredict), 1);
      chk("t2_model_ctr4", m_ctr[4], 3);
      step(1, 1, 32'h10, 4'h0, 0, 0);
      chk("t2_pred_ctr", int'(pred_ctr), 3);
      chk("t2_pred_taken", int'(pred_taken), 1);
      step(1, 0, 32'h0, 4'h0, 1, 1);
      chk("t2_mis_c", int'(mispredict), 0);

      // 3: history steers to untouched idx 0
      step(1, 1, 32'h10, 4'h4, 0, 0);
      chk("t3_pred_ctr", int'(pred_ctr), 1);
      step(1, 0, 32'h0, 4'h0, 1, 0);
      chk("t3_mis", int'(mispredict), 0);

      // EN=0 freezes everything
      step(1, 1, 32'h30, 4'h0, 0, 0);
      step(0, 1, 32'h10, 4'h0, 1, 1);
      chk("en0_pred_valid", int'(pred_valid), 0);
      step(1, 0, 32'h0, 4'h0, 1, 1);

      // 4: fill, reject, then predict+resolve while full
      step(1, 1, 32'h20, 4'h0, 0, 0);
      step(1, 1, 32'h24, 4'h0, 0, 0);
      step(1, 1, 32'h28, 4'h0, 0, 0);
      step(1, 1, 32'h2c, 4'h0, 0, 0);
      chk("t4_q_full", int'(q_full), 1);
      step(1, 1, 32'h30, 4'h0, 0, 0);
      chk("t4_reject", int'(pred_valid), 0);
      step(1, 1, 32'h30, 4'h0, 1, 1);
      chk("t4_both_valid", int'(pred_valid), 1);
      chk("t4_both_full", int'(q_full), 1);
      for (int k = 0; k < DEPTH; k++) step(1, 0, 32'h0, 4'h0, 1, k[0]);
      chk("t4_drained", int'(q_empty), 1);

      // 5: resolve on empty, then same-index predict+resolve
      step(1, 0, 32'h0, 4'h0, 1, 1);
      chk("t5_empty_mis", int'(mispredict), 0);
      step(1, 1, 32'h14, 4'h0, 0, 0);
      chk("t5_first_ctr", int'(pred_ctr), 1);
      step(1, 1, 32'h14, 4'h0, 1, 1);
      chk("t5_same_idx_ctr", int'(pred_ctr), BYP ? 2 : 1);
      step(1, 0, 32'h0, 4'h0, 1, 1);

      // 6: reset with entries in flight
      step(1, 1, 32'h10, 4'h0, 0, 0);
      step(1, 1, 32'h10, 4'h0, 0, 0);
      chk("t6_pre_ctr", int'(pred_ctr), 3);
      rst = 1;
      model_reset();
      #1;
      chk("t6_rst_empty", int'(q_empty), 1);
      chk("t6_rst_pred_valid", int'(pred_valid), 0);
      chk("t6_rst_pred_ctr", int'(pred_ctr), 0);
      @(negedge clk);
      #1;
      rst = 0;
      step(1, 1, 32'h10, 4'h0, 0, 0);
      chk("t6_post_ctr", int'(pred_ctr), 1);
      step(1, 0, 32'h0, 4'h0, 1, 0);

      chk_on = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/gshare_pht.md
Name: gshare_pht

Overview:
- Pattern history table directly downstream of the GBHR; consumes its gbhr output.
- Forms a gshare index from PC XOR gbhr and returns a registered taken/not-taken prediction from a table of 2-bit saturating counters.
- Keeps each prediction's index in a small in-flight queue, so the resolve-time update hits the entry actually used at predict time.

Parameters:
- W_PHT, 4: index width; table holds 2^W_PHT counters; must equal the GBHR width.
- W_PC, 32: PC width; must be >= W_PHT+2.
- DEPTH, 4: in-flight queue entries (power of two, >= 2).
- INIT_CTR, 2'b01: counter reset value (weakly not-taken).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- EN  input  1  global enable; 0 freezes all state.
- predict  input  1  prediction request.
- pc  input  W_PC  branch PC, sampled with predict.
- gbhr  input  W_PHT  global history from the GBHR, sampled with predict.
- resolve  input  1  oldest in-flight branch resolves this cycle.
- br_taken  input  1  actual outcome, valid with resolve.
- pred_valid  output  1  one-cycle pulse: pred_taken/pred_ctr valid.
- pred_taken  output  1  predicted direction (counter MSB).
- pred_ctr  output  2  counter value used for the prediction.
- mispredict  output  1  one-cycle pulse: resolved outcome differed from its prediction.
- q_full  output  1  in-flight queue holds DEPTH entries.
- q_empty  output  1  in-flight queue holds 0 entries.

Behaviour:
- Reset (rst=1, asynchronous, active-high; the polarity and synchronicity are fixed):
  - all counters <= INIT_CTR; queue pointers and count <= 0.
  - pred_valid, pred_taken, pred_ctr, mispredict <= 0; q_empty=1, q_full=0.
  - Reset mid-operation discards every in-flight entry.
- Index: idx = pc[W_PHT+1:2] ^ gbhr. Word-aligned PC bits; pc[1:0] ignored.
- Predict accept: EN && predict && (!q_full || resolve-accept same cycle).
  - Cycle N+1: pred_valid=1, pred_ctr=ctr[idx], pred_taken=ctr[idx][1].
  - Push {idx, pred_taken} at the queue tail.
  - Rejected predict: pred_valid=0, no push.
- Resolve accept: EN && resolve && !q_empty.
  - Pop the head entry and update ctr[head.idx]:
    - br_taken=1: sat-inc (3 stays 3).
    - br_taken=0: sat-dec (0 stays 0).
  - Cycle N+1: mispredict = (head.pred != br_taken).
  - Resolve on empty: ignored, mispredict=0, no counter change.
- Simultaneous accepted predict and resolve:
  - both occur; count unchanged; allowed when full.
  - If idx equals head.idx, the prediction reads the pre-update counter (bypass disabled).
- EN=0: no reads, pushes, pops or writes; pred_valid=0, mispredict=0; pred_taken/pred_ctr hold.
- Queue flags: q_full = (count==DEPTH), q_empty = (count==0), both combinational from registered count. Pointers wrap modulo DEPTH.
- Latency: prediction 1 cycle, mispredict 1 cycle, counter update visible to predicts from the cycle after resolve.

Optional Feature:
- PHT_BYPASS_EN defined: on a same-cycle predict/resolve to the same index, prediction uses the post-update (saturated) counter value.
- Undefined: prediction uses the pre-update value, as above.

Decomposition:
- Package bp_pkg:
  - ctr_t (2-bit) type.
  - constants SNT=0, WNT=1, WT=2, ST=3.
  - pure functions sat_inc/sat_dec.
  - inflight_t struct {idx, pred}.
- Sub-module bp_inflight_fifo: DEPTH-entry synchronous FIFO with push/pop/full/empty and simultaneous push+pop when full.

Test Plan:
1. Reset, predict pc=0x10, gbhr=0000 -> idx=4; next cycle pred_valid=1, pred_ctr=01, pred_taken=0; q_empty=0.
2. Two predicts pc=0x10/gbhr=0000, then two resolves br_taken=1 -> ctr[4] 01->10->11, mispredict=1 on both; a third predict then returns pred_ctr=11, pred_taken=1; a further taken resolve leaves 11 with mispredict=0.
3. After scenario 2, predict pc=0x10, gbhr=0100 -> idx=0, pred_ctr=01 (untouched entry).
4. Four predicts -> q_full=1; fifth predict alone -> pred_valid=0; predict+resolve same cycle while full -> pred_valid=1, q_full stays 1.
5. Resolve with q_empty=1 -> mispredict=0, no counters change. Same-cycle predict+resolve(taken) on ctr=01 at the same idx -> pred_ctr=01 without PHT_BYPASS_EN, 10 with it.
6. rst pulse with 2 entries in flight and ctr[4]=11 -> immediately q_empty=1, outputs 0; after release, predict at idx 4 returns pred_ctr=01.
